// File: rtl/dpram_pkg.sv
`default_nettype none
// ============================================================================
// dpram_pkg : shared constants, sweep state type and byte-lane merge helper
// Rev 1.0
// ============================================================================
package dpram_pkg;

   localparam int RDW_NEW = 0;
   localparam int RDW_OLD = 1;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } sweep_state_t;

   // One byte lane of a read-modify view: new data where the lane is enabled.
   function automatic logic [7:0] merge_be(input logic [7:0] old_b,
                                           input logic [7:0] new_b,
                                           input logic       be);
      return be ? new_b : old_b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dpram_clear_seq.sv
`default_nettype none
// ============================================================================
// dpram_clear_seq : walks every address once, writing the init word
// Rev 1.0
// ============================================================================
module dpram_clear_seq
   import dpram_pkg::*;
#(
   parameter int AW             = 4,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          i_clear,
   output logic          o_busy,
   output logic          o_clear_done,
   output logic [AW-1:0] o_sweep_addr,
   output logic          o_sweep_we
);

   localparam logic [AW-1:0] LAST_ADDR = '1;

   sweep_state_t  r_state;
   sweep_state_t  w_state_nxt;
   logic [AW-1:0] r_addr;
   logic [AW-1:0] w_addr_nxt;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         if (CLEAR_ON_RESET) r_state <= SWEEP;
         else                r_state <= IDLE;
         r_addr <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_addr  <= w_addr_nxt;
      end
   end

   // A clear request always wins, so an aborted sweep never reports done.
   always_comb begin
      w_state_nxt  = r_state;
      w_addr_nxt   = r_addr;
      o_clear_done = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_clear) begin
               w_state_nxt = SWEEP;
               w_addr_nxt  = '0;
            end
         end
         SWEEP: begin
            if (i_clear) begin
               w_addr_nxt = '0;
            end else if (r_addr == LAST_ADDR) begin
               o_clear_done = reset_n;
               w_state_nxt  = IDLE;
               w_addr_nxt   = '0;
            end else begin
               w_addr_nxt = r_addr + 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign o_busy       = (r_state == SWEEP);
   assign o_sweep_we   = o_busy & reset_n;
   assign o_sweep_addr = r_addr;

endmodule
`default_nettype wire

// File: rtl/dpram_be_sweep.sv
`default_nettype none
// ============================================================================
// dpram_be_sweep : true dual-port byte-enable RAM with init clear sweep
// Rev 1.0
// ============================================================================
module dpram_be_sweep
   import dpram_pkg::*;
#(
   parameter int                    widthad_a      = 15,
   parameter int                    DATA_WIDTH     = 8,
   parameter int                    RDW_MODE       = RDW_NEW,
   parameter bit                    OUT_REG        = 1'b0,
   parameter bit                    CLEAR_ON_RESET = 1'b1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    clear,
   output logic                    busy,
   output logic                    clear_done,
   input  logic [widthad_a-1:0]    address_a,
   input  logic [DATA_WIDTH-1:0]   data_a,
   input  logic [DATA_WIDTH/8-1:0] byteena_a,
   input  logic                    wren_a,
   output logic [DATA_WIDTH-1:0]   q_a,
   input  logic [widthad_a-1:0]    address_b,
   input  logic [DATA_WIDTH-1:0]   data_b,
   input  logic [DATA_WIDTH/8-1:0] byteena_b,
   input  logic                    wren_b,
   output logic [DATA_WIDTH-1:0]   q_b
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int DEPTH = 1 << widthad_a;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic                  w_busy;
   logic                  w_sweep_we;
   logic [widthad_a-1:0]  w_sweep_addr;
   logic                  w_user_we_a;
   logic                  w_user_we_b;
   logic                  w_wr_we_a;
   logic [widthad_a-1:0]  w_wr_addr_a;
   logic [DATA_WIDTH-1:0] w_wr_data_a;
   logic [NB-1:0]         w_wr_be_a;
   logic [DATA_WIDTH-1:0] w_old_a;
   logic [DATA_WIDTH-1:0] w_old_b;
   logic [DATA_WIDTH-1:0] w_rdw_a;
   logic [DATA_WIDTH-1:0] w_rdw_b;
   logic [DATA_WIDTH-1:0] r_q1_a;
   logic [DATA_WIDTH-1:0] r_q1_b;
   logic [DATA_WIDTH-1:0] w_q_a;
   logic [DATA_WIDTH-1:0] w_q_b;

   dpram_clear_seq #(
      .AW             (widthad_a),
      .CLEAR_ON_RESET (CLEAR_ON_RESET)
   ) u_clear_seq (
      .clock        (clock),
      .reset_n      (reset_n),
      .i_clear      (clear),
      .o_busy       (w_busy),
      .o_clear_done (clear_done),
      .o_sweep_addr (w_sweep_addr),
      .o_sweep_we   (w_sweep_we)
   );

   assign busy        = w_busy;
   assign w_user_we_a = wren_a & reset_n & ~w_busy;
   assign w_user_we_b = wren_b & reset_n & ~w_busy;

   // The sweep borrows port A; port B is simply gated off while busy.
   assign w_wr_we_a   = w_sweep_we | w_user_we_a;
   assign w_wr_addr_a = w_busy ? w_sweep_addr : address_a;
   assign w_wr_data_a = w_busy ? INIT_VALUE   : data_a;
   assign w_wr_be_a   = w_busy ? {NB{1'b1}}   : byteena_a;

   // Port A is written last so its enabled lanes win a same-address collision.
   always_ff @(posedge clock) begin
      for (int i = 0; i < NB; i++) begin
         if (w_user_we_b && byteena_b[i])
            r_mem[address_b][8*i +: 8] <= data_b[8*i +: 8];
         if (w_wr_we_a && w_wr_be_a[i])
            r_mem[w_wr_addr_a][8*i +: 8] <= w_wr_data_a[8*i +: 8];
      end
   end

   assign w_old_a = r_mem[address_a];
   assign w_old_b = r_mem[address_b];

   for (genvar i = 0; i < NB; i++) begin : g_lane
      assign w_rdw_a[8*i +: 8] = (RDW_MODE == RDW_OLD) ? w_old_a[8*i +: 8] :
         merge_be(w_old_a[8*i +: 8], data_a[8*i +: 8], w_user_we_a & byteena_a[i]);
      assign w_rdw_b[8*i +: 8] = (RDW_MODE == RDW_OLD) ? w_old_b[8*i +: 8] :
         merge_be(w_old_b[8*i +: 8], data_b[8*i +: 8], w_user_we_b & byteena_b[i]);
   end

   always_ff @(posedge clock) begin
      if (!reset_n || w_busy) begin
         r_q1_a <= '0;
         r_q1_b <= '0;
      end else begin
         r_q1_a <= w_rdw_a;
         r_q1_b <= w_rdw_b;
      end
   end

   if (OUT_REG) begin : g_out_reg
      logic [DATA_WIDTH-1:0] r_q2_a;
      logic [DATA_WIDTH-1:0] r_q2_b;
      always_ff @(posedge clock) begin
         if (!reset_n || w_busy) begin
            r_q2_a <= '0;
            r_q2_b <= '0;
         end else begin
            r_q2_a <= r_q1_a;
            r_q2_b <= r_q1_b;
         end
      end
      assign w_q_a = r_q2_a;
      assign w_q_b = r_q2_b;
   end else begin : g_no_out_reg
      assign w_q_a = r_q1_a;
      assign w_q_b = r_q1_b;
   end

   assign q_a = w_busy ? '0 : w_q_a;
   assign q_b = w_busy ? '0 : w_q_b;

endmodule
`default_nettype wire

// File: tb/tb_dpram_be_sweep.sv
`default_nettype none
// ============================================================================
// tb_dpram_be_sweep : directed checks on a 32-bit new-data instance and a
// 16-bit old-data, output-registered, no-auto-clear instance. Rev 1.0
// ============================================================================
module tb_dpram_be_sweep;

   localparam logic [31:0] INIT0 = 32'hA5A5_0F0F;
   localparam logic [15:0] INIT1 = 16'h1234;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        clr0, busy0, done0;
   logic [3:0]  a0a, a0b, be0a, be0b;
   logic [31:0] d0a, d0b, q0a, q0b;
   logic        we0a, we0b;
   logic        clr1, busy1, done1;
   logic [3:0]  a1a, a1b;
   logic [1:0]  be1a, be1b;
   logic [15:0] d1a, d1b, q1a, q1b;
   logic        we1a, we1b;

   int n_pass  = 0;
   int n_total = 0;

   dpram_be_sweep #(
      .widthad_a(4), .DATA_WIDTH(32), .RDW_MODE(0), .OUT_REG(1'b0),
      .CLEAR_ON_RESET(1'b1), .INIT_VALUE(INIT0)
   ) dut0 (
      .clock(clk), .reset_n(rst_n), .clear(clr0), .busy(busy0), .clear_done(done0),
      .address_a(a0a), .data_a(d0a), .byteena_a(be0a), .wren_a(we0a), .q_a(q0a),
      .address_b(a0b), .data_b(d0b), .byteena_b(be0b), .wren_b(we0b), .q_b(q0b)
   );

   dpram_be_sweep #(
      .widthad_a(4), .DATA_WIDTH(16), .RDW_MODE(1), .OUT_REG(1'b1),
      .CLEAR_ON_RESET(1'b0), .INIT_VALUE(INIT1)
   ) dut1 (
      .clock(clk), .reset_n(rst_n), .clear(clr1), .busy(busy1), .clear_done(done1),
      .address_a(a1a), .data_a(d1a), .byteena_a(be1a), .wren_a(we1a), .q_a(q1a),
      .address_b(a1b), .data_b(d1b), .byteena_b(be1b), .wren_b(we1b), .q_b(q1b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clr0 = 0; a0a = 0; a0b = 0; be0a = 0; be0b = 0; d0a = 0; d0b = 0; we0a = 0; we0b = 0;
      clr1 = 0; a1a = 0; a1b = 0; be1a = 0; be1b = 0; d1a = 0; d1b = 0; we1a = 0; we1b = 0;
      repeat (3) tick();
      n_total++; if ({q0a, q0b} !== 64'h0) $display("FAIL reset_q0: got %h/%h exp 0/0", q0a, q0b); else n_pass++;
      n_total++; if ({q1a, q1b} !== 32'h0) $display("FAIL reset_q1: got %h/%h exp 0/0", q1a, q1b); else n_pass++;
      n_total++; if (busy0 !== 1'b1) $display("FAIL reset_busy0: got %b exp 1", busy0); else n_pass++;
      n_total++; if (busy1 !== 1'b0) $display("FAIL reset_busy1: got %b exp 0", busy1); else n_pass++;
      n_total++; if ({done0, done1} !== 2'b00) $display("FAIL reset_done: got %b%b exp 00", done0, done1); else n_pass++;
   endtask

   task automatic test_sweep();
      int cnt = 0;
      int done_at = 0;
      rst_n = 1'b1;
      #1;
      while (busy0 && cnt < 40) begin
         cnt++;
         if (done0) done_at = cnt;
         tick();
      end
      n_total++; if (cnt != 16) $display("FAIL sweep_len: got %0d exp 16", cnt); else n_pass++;
      n_total++; if (done_at != 16) $display("FAIL sweep_done_cycle: got %0d exp 16", done_at); else n_pass++;
      for (int k = 0; k < 16; k++) begin
         a0a = 4'(k);
         tick();
         n_total++; if (q0a !== INIT0) $display("FAIL sweep_read[%0d]: got %h exp %h", k, q0a, INIT0); else n_pass++;
      end
   endtask

   task automatic test_byteena();
      a0a = 4'd5; d0a = 32'h1122_3344; be0a = 4'b1111; we0a = 1'b1;
      tick();
      d0a = 32'hAABB_CCDD; be0a = 4'b0101;
      tick();
      n_total++; if (q0a !== 32'h11BB_33DD) $display("FAIL be_rdw_new: got %h exp 11bb33dd", q0a); else n_pass++;
      d0a = 32'hFFFF_FFFF; be0a = 4'b0000;
      tick();
      n_total++; if (q0a !== 32'h11BB_33DD) $display("FAIL be_zero_read: got %h exp 11bb33dd", q0a); else n_pass++;
      we0a = 1'b0;
      tick();
      n_total++; if (q0a !== 32'h11BB_33DD) $display("FAIL be_readback: got %h exp 11bb33dd", q0a); else n_pass++;
   endtask

   task automatic test_rdw();
      a0a = 4'd3; d0a = 32'h5A5A_5A5A; be0a = 4'b1111; we0a = 1'b1;
      a0b = 4'd4; d0b = 32'h0102_0304; be0b = 4'b1100; we0b = 1'b1;
      tick();
      n_total++; if (q0a !== 32'h5A5A_5A5A) $display("FAIL rdw_new_a: got %h exp 5a5a5a5a", q0a); else n_pass++;
      n_total++; if (q0b !== 32'h0102_0F0F) $display("FAIL rdw_new_b: got %h exp 01020f0f", q0b); else n_pass++;
      we0a = 1'b0; we0b = 1'b0;
      tick();
   endtask

   task automatic test_collision();
      a0a = 4'd7; d0a = 32'h1111_1111; be0a = 4'b0001; we0a = 1'b1;
      a0b = 4'd7; d0b = 32'h2222_2222; be0b = 4'b0011; we0b = 1'b1;
      tick();
      n_total++; if (q0a !== 32'hA5A5_0F11) $display("FAIL coll_q_a: got %h exp a5a50f11", q0a); else n_pass++;
      n_total++; if (q0b !== 32'hA5A5_2222) $display("FAIL coll_q_b: got %h exp a5a52222", q0b); else n_pass++;
      d0a = 32'hCAFE_F00D; be0a = 4'b1111; we0b = 1'b0;
      tick();
      n_total++; if (q0b !== 32'hA5A5_2211) $display("FAIL cross_old_b: got %h exp a5a52211", q0b); else n_pass++;
      n_total++; if (q0a !== 32'hCAFE_F00D) $display("FAIL cross_new_a: got %h exp cafef00d", q0a); else n_pass++;
      we0a = 1'b0;
      tick();
      n_total++; if (q0b !== 32'hCAFE_F00D) $display("FAIL cross_after_b: got %h exp cafef00d", q0b); else n_pass++;
   endtask

   task automatic test_clear_restart();
      int cnt = 0;
      int done_at = 0;
      bit zero_ok = 1'b1;
      clr0 = 1'b1;
      tick();
      clr0 = 1'b0;
      a0a = 4'd0; d0a = 32'hFFFF_FFFF; be0a = 4'b1111; we0a = 1'b1;
      a0b = 4'd1; d0b = 32'hFFFF_FFFF; be0b = 4'b1111; we0b = 1'b1;
      for (int k = 0; k < 9; k++) begin
         if (q0a !== 32'h0 || q0b !== 32'h0 || done0 !== 1'b0) zero_ok = 1'b0;
         tick();
      end
      clr0 = 1'b1;
      tick();
      clr0 = 1'b0;
      while (busy0 && cnt < 40) begin
         cnt++;
         if (done0) done_at = cnt;
         if (q0a !== 32'h0 || q0b !== 32'h0) zero_ok = 1'b0;
         tick();
      end
      we0a = 1'b0; we0b = 1'b0;
      n_total++; if (cnt != 16) $display("FAIL restart_len: got %0d exp 16", cnt); else n_pass++;
      n_total++; if (done_at != 16) $display("FAIL restart_done_cycle: got %0d exp 16", done_at); else n_pass++;
      n_total++; if (!zero_ok) $display("FAIL busy_q_zero: got nonzero q or early done exp 0"); else n_pass++;
      a0a = 4'd0; a0b = 4'd1;
      tick();
      n_total++; if (q0a !== INIT0) $display("FAIL drop_write_a: got %h exp %h", q0a, INIT0); else n_pass++;
      n_total++; if (q0b !== INIT0) $display("FAIL drop_write_b: got %h exp %h", q0b, INIT0); else n_pass++;
      a0a = 4'd7;
      tick();
      n_total++; if (q0a !== INIT0) $display("FAIL reclear_7: got %h exp %h", q0a, INIT0); else n_pass++;
   endtask

   task automatic test_outreg_rdw_old();
      int cnt = 0;
      clr1 = 1'b1;
      tick();
      clr1 = 1'b0;
      while (busy1 && cnt < 40) begin
         cnt++;
         tick();
      end
      n_total++; if (cnt != 16) $display("FAIL clr1_len: got %0d exp 16", cnt); else n_pass++;
      a1a = 4'd3;
      tick();
      tick();
      n_total++; if (q1a !== INIT1) $display("FAIL clr1_read: got %h exp %h", q1a, INIT1); else n_pass++;
      a1a = 4'd2; d1a = 16'hBEEF; be1a = 2'b11; we1a = 1'b1;
      tick();
      we1a = 1'b0;
      tick();
      n_total++; if (q1a !== 16'h1234) $display("FAIL lat2_old_2: got %h exp 1234", q1a); else n_pass++;
      a1a = 4'd3; d1a = 16'h005A; we1a = 1'b1;
      tick();
      n_total++; if (q1a !== 16'hBEEF) $display("FAIL lat2_read_2: got %h exp beef", q1a); else n_pass++;
      we1a = 1'b0;
      tick();
      n_total++; if (q1a !== 16'h1234) $display("FAIL rdw_old_3: got %h exp 1234", q1a); else n_pass++;
      tick();
      n_total++; if (q1a !== 16'h005A) $display("FAIL rdw_after_3: got %h exp 005a", q1a); else n_pass++;
      a1a = 4'd7; d1a = 16'h1111; be1a = 2'b01; we1a = 1'b1;
      a1b = 4'd7; d1b = 16'h2222; be1b = 2'b11; we1b = 1'b1;
      tick();
      we1a = 1'b0; we1b = 1'b0;
      tick();
      n_total++; if ({q1a, q1b} !== 32'h1234_1234) $display("FAIL coll1_old: got %h/%h exp 1234/1234", q1a, q1b); else n_pass++;
      tick();
      n_total++; if (q1a !== 16'h2211) $display("FAIL coll1_merge: got %h exp 2211", q1a); else n_pass++;
   endtask

   task automatic test_reset_midsweep();
      int cnt = 0;
      int done_at = 0;
      clr0 = 1'b1;
      tick();
      clr0 = 1'b0;
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      n_total++; if ({q0a, q1a} !== 48'h0) $display("FAIL midrst_q: got %h/%h exp 0/0", q0a, q1a); else n_pass++;
      n_total++; if ({busy0, busy1} !== 2'b10) $display("FAIL midrst_busy: got %b%b exp 10", busy0, busy1); else n_pass++;
      rst_n = 1'b1;
      #1;
      while (busy0 && cnt < 40) begin
         cnt++;
         if (done0) done_at = cnt;
         tick();
      end
      n_total++; if (cnt != 16 || done_at != 16) $display("FAIL midrst_resweep: got %0d/%0d exp 16/16", cnt, done_at); else n_pass++;
      n_total++; if (q1a !== 16'h2211) $display("FAIL midrst_retain1: got %h exp 2211", q1a); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_byteena();
      test_rdw();
      test_collision();
      test_clear_restart();
      test_outreg_rdw_old();
      test_reset_midsweep();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
